// File: rtl/bip_program_loader.sv
// rtl/bip_program_loader.sv - assembles UART bytes into instruction words and writes BIP program memory
module bip_program_loader #(
  parameter int NBITS_O = 11,
  parameter int NBITS_D = 16,
  parameter int OPCODE  = 5,
  parameter int CELDAS  = 10
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_pm_wr,
  output logic [NBITS_O-1:0] o_pm_addr,
  output logic [NBITS_D-1:0] o_pm_data,
  output logic               o_cpu_run,
  output logic               o_done,
  output logic               o_overflow,
  output logic [NBITS_O-1:0] o_word_count
);

  typedef enum logic [2:0] {IDLE, WAIT_HI, WAIT_LO, WRITE, DONE} state_t;

  localparam logic [NBITS_O-1:0] LAST_ADDR = NBITS_O'(CELDAS - 1);

  state_t             state;
  state_t             state_next;
  logic [7:0]         hi_byte;
  logic [NBITS_O-1:0] count;
  logic [NBITS_O-1:0] pm_addr;
  logic [NBITS_D-1:0] pm_data;
  logic               overflow;
  logic               is_hlt;
  logic               is_full;
  logic               load_start;
  logic               write_more;

  assign is_hlt     = (pm_data[NBITS_D-1 -: OPCODE] == '0);
  assign is_full    = (count == LAST_ADDR);
  assign load_start = ((state == IDLE) || (state == DONE)) && i_start;
  // A byte arriving in the WRITE cycle is kept only if another word is expected.
  assign write_more = (state == WRITE) && !is_hlt && !is_full;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_start) state_next = WAIT_HI;
      WAIT_HI: if (i_rx_valid) state_next = WAIT_LO;
      WAIT_LO: if (i_rx_valid) state_next = WRITE;
      WRITE: begin
        if (is_hlt || is_full) state_next = DONE;
        else if (i_rx_valid)   state_next = WAIT_LO;
        else                   state_next = WAIT_HI;
      end
      DONE:    if (i_start) state_next = WAIT_HI;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_pm_wr   = (state == WRITE);
    o_cpu_run = (state == DONE);
    o_done    = (state == DONE);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      hi_byte  <= '0;
      count    <= '0;
      pm_addr  <= '0;
      pm_data  <= '0;
      overflow <= 1'b0;
    end else begin
      if (load_start) begin
        count    <= '0;
        overflow <= 1'b0;
      end
      if (((state == WAIT_HI) || write_more) && i_rx_valid)
        hi_byte <= i_rx_data;
      if ((state == WAIT_LO) && i_rx_valid) begin
        pm_data <= NBITS_D'({hi_byte, i_rx_data});
        pm_addr <= count;
      end
      if (state == WRITE) begin
        count <= count + 1'b1;
        if (!is_hlt && is_full) overflow <= 1'b1;
      end
    end
  end

  assign o_pm_addr    = pm_addr;
  assign o_pm_data    = pm_data;
  assign o_overflow   = overflow;
  assign o_word_count = count;

endmodule

// File: tb/tb_bip_program_loader.sv
// tb/tb_bip_program_loader.sv - scoreboard bench for bip_program_loader
module tb_bip_program_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        pm_wr;
  logic [10:0] pm_addr;
  logic [15:0] pm_data;
  logic        cpu_run;
  logic        done;
  logic        overflow;
  logic [10:0] word_count;

  typedef struct packed {
    logic [10:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [10:0] exp_addr;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  bip_program_loader #(.NBITS_O(11), .NBITS_D(16), .OPCODE(5), .CELDAS(10)) dut (
    .i_clock     (clk),
    .i_reset     (rst_n),
    .i_start     (start),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .o_pm_wr     (pm_wr),
    .o_pm_addr   (pm_addr),
    .o_pm_data   (pm_data),
    .o_cpu_run   (cpu_run),
    .o_done      (done),
    .o_overflow  (overflow),
    .o_word_count(word_count)
  );

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (pm_wr === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=%h, none expected", pm_addr, pm_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if ({pm_addr, pm_data} !== e) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   pm_addr, pm_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    tick(gap);
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[15:8], 1);
    exp_q.push_back({exp_addr, w});
    exp_addr = exp_addr + 11'd1;
    send_byte(w[7:0], 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    exp_addr = '0;
    tick(2);
    chk("reset_pm_wr",    32'(pm_wr),      32'd0);
    chk("reset_cpu_run",  32'(cpu_run),    32'd0);
    chk("reset_done",     32'(done),       32'd0);
    chk("reset_count",    32'(word_count), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // bytes in IDLE are ignored
    send_byte(8'h08, 1);
    send_byte(8'h05, 1);
    chk("idle_count",   32'(word_count), 32'd0);
    chk("idle_cpu_run", 32'(cpu_run),    32'd0);

    // basic load
    pulse_start();
    exp_addr = '0;
    send_word(16'h0805);
    send_word(16'h1803);
    send_word(16'h0000);
    tick(1);
    chk("basic_done",     32'(done),       32'd1);
    chk("basic_cpu_run",  32'(cpu_run),    32'd1);
    chk("basic_overflow", 32'(overflow),   32'd0);
    chk("basic_count",    32'(word_count), 32'd3);

    // bytes in DONE are ignored
    send_byte(8'h08, 1);
    send_byte(8'h01, 1);
    chk("done_count",   32'(word_count), 32'd3);
    chk("done_cpu_run", 32'(cpu_run),    32'd1);

    // reload
    pulse_start();
    chk("reload_done_drop", 32'(done),    32'd0);
    chk("reload_run_drop",  32'(cpu_run), 32'd0);
    exp_addr = '0;
    send_word(16'h0000);
    tick(1);
    chk("reload_done",  32'(done),       32'd1);
    chk("reload_count", 32'(word_count), 32'd1);

    // overflow: ten non-HLT words fill memory
    pulse_start();
    exp_addr = '0;
    for (int i = 0; i < 10; i++) send_word(16'h0801);
    tick(1);
    chk("ovf_done",     32'(done),       32'd1);
    chk("ovf_overflow", 32'(overflow),   32'd1);
    chk("ovf_count",    32'(word_count), 32'd10);
    send_byte(8'h08, 1);
    send_byte(8'h01, 1);
    tick(2);
    chk("ovf_extra_count", 32'(word_count), 32'd10);

    // reset while waiting for a low byte
    pulse_start();
    exp_addr = '0;
    send_word(16'h1803);
    send_word(16'h1803);
    send_byte(8'h08, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pm_wr",    32'(pm_wr),      32'd0);
    chk("mid_rst_addr",     32'(pm_addr),    32'd0);
    chk("mid_rst_data",     32'(pm_data),    32'd0);
    chk("mid_rst_count",    32'(word_count), 32'd0);
    chk("mid_rst_cpu_run",  32'(cpu_run),    32'd0);
    chk("mid_rst_done",     32'(done),       32'd0);
    chk("mid_rst_overflow", 32'(overflow),   32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // back-to-back: next high byte arrives in the WRITE cycle
    pulse_start();
    exp_addr = '0;
    send_byte(8'h08, 1);
    exp_q.push_back({11'd0, 16'h0805});
    send_byte(8'h05, 0);
    send_byte(8'h18, 0);
    exp_q.push_back({11'd1, 16'h1803});
    send_byte(8'h03, 1);
    exp_addr = 11'd2;
    send_word(16'h0000);
    tick(1);
    chk("b2b_count", 32'(word_count), 32'd3);
    chk("b2b_done",  32'(done),       32'd1);

    tick(3);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
